// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional return-address stack is enabled by defining RAS_EN.
package pc_seq_pkg;

    localparam int              PC_W      = 12;
    localparam logic [PC_W-1:0] RESET_PC  = 12'h000;
    localparam int              RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_BRANCH = 2'd1,
        CAUSE_CALL   = 2'd2,
        CAUSE_RET    = 2'd3
    } cause_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/fetch bundle between the execute/branch unit and the PC sequencer.
// Handshake: requests are level signals sampled at each rising clk edge; the
// sequencer answers only through registered outputs one cycle later.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_pc;
    logic            call;
    logic            ret;
    logic            halt_req;
    logic            resume;

    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic            flush;
    logic            halted;
    logic            ras_err;
    state_t          dbg_state;

    modport master (
        output stall, br_taken, br_pc, call, ret, halt_req, resume,
        input  pc, pc_valid, flush, halted, ras_err, dbg_state
    );

    modport slave (
        input  stall, br_taken, br_pc, call, ret, halt_req, resume,
        output pc, pc_valid, flush, halted, ras_err, dbg_state
    );

endinterface

// File: rtl/pc_sequencer_ret_addr_stack.sv
// Circular return-address stack; built only when RAS_EN is defined.
// Overflow overwrites the oldest entry, underflow leaves it untouched; both set a sticky err.
`ifdef RAS_EN
module ret_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int W     = PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_err
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_sp;
    logic [AW:0]   r_count;
    logic          r_err;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_sp_inc;

    always_comb begin
        w_top    = (r_sp == '0)   ? LAST : r_sp - 1'b1;
        w_sp_inc = (r_sp == LAST) ? '0   : r_sp + 1'b1;
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_rdata = r_mem[w_top];
    assign o_err   = r_err;

    // When full, r_sp already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (i_pop) begin
            if (o_empty) begin
                r_err <= 1'b1;
            end else begin
                r_sp    <= w_top;
                r_count <= r_count - 1'b1;
            end
        end else if (i_push) begin
            r_sp <= w_sp_inc;
            if (o_full) begin
                r_err <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_pop) begin
            r_mem[r_sp] <= i_wdata;
        end
    end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, redirect arbitration, flush and halt.
// Define RAS_EN to build the return-address stack for call/ret.
module pc_sequencer #(
    parameter logic [pc_seq_pkg::PC_W-1:0] RESET_PC = pc_seq_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    import pc_seq_pkg::*;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_flush;
    logic            r_halted;

    cause_t          w_cause;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_hold;
    logic            w_run_act;
    logic            w_push;
    logic            w_pop;

    assign w_pc_inc  = pc_inc(r_pc);
    assign w_run_act = (r_state == ST_RUN) && !bus.halt_req;

`ifdef RAS_EN
    logic [PC_W-1:0] w_ras_rdata;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic            w_ras_err;

    ret_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_pc_inc),
        .o_rdata (w_ras_rdata),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full),
        .o_err   (w_ras_err)
    );

    logic w_unused_full;
    assign w_unused_full = w_ras_full;

    // A ret on an empty stack still pops (to flag underflow) but advances like a plain increment.
    always_comb begin
        w_cause  = CAUSE_NONE;
        w_target = w_pc_inc;
        w_hold   = bus.stall;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (bus.ret) begin
            w_pop  = w_run_act;
            w_hold = 1'b0;
            if (!w_ras_empty) begin
                w_cause  = CAUSE_RET;
                w_target = w_ras_rdata;
            end
        end else if (bus.call) begin
            w_cause  = CAUSE_CALL;
            w_target = bus.br_pc;
            w_push   = w_run_act;
        end else if (bus.br_taken) begin
            w_cause  = CAUSE_BRANCH;
            w_target = bus.br_pc;
        end
    end

    assign bus.ras_err = w_ras_err;
`else
    logic w_unused_ret;
    logic w_unused_push;
    logic w_unused_pop;
    assign w_unused_ret  = bus.ret;
    assign w_unused_push = w_push;
    assign w_unused_pop  = w_pop;

    // Without a stack, call is just a branch and ret never redirects.
    always_comb begin
        w_cause  = CAUSE_NONE;
        w_target = w_pc_inc;
        w_hold   = bus.stall;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (bus.call) begin
            w_cause  = CAUSE_CALL;
            w_target = bus.br_pc;
        end else if (bus.br_taken) begin
            w_cause  = CAUSE_BRANCH;
            w_target = bus.br_pc;
        end
    end

    assign bus.ras_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (bus.halt_req) begin
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                        r_pc_valid <= 1'b0;
                    end else if (w_cause != CAUSE_NONE) begin
                        r_state    <= ST_FLUSH;
                        r_pc       <= w_target;
                        r_flush    <= 1'b1;
                        r_pc_valid <= 1'b0;
                    end else if (!w_hold) begin
                        r_pc <= w_pc_inc;
                    end
                end
                ST_FLUSH: begin
                    r_state    <= ST_RUN;
                    r_flush    <= 1'b0;
                    r_pc_valid <= 1'b1;
                end
                ST_HALT: begin
                    if (bus.resume && !bus.halt_req) begin
                        r_state    <= ST_RUN;
                        r_halted   <= 1'b0;
                        r_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_pc_valid <= 1'b0;
                    r_flush    <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_valid  = r_pc_valid;
    assign bus.flush     = r_flush;
    assign bus.halted    = r_halted;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a queue-based model.
// RAS_EN selects the call/ret behaviour in the reference model as well.
module tb_pc_sequencer;

    localparam int W         = 12;
    localparam int RAS_DEPTH = 4;
`ifdef RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();
    pc_sequencer_if bus_b ();

    pc_sequencer #(.RESET_PC(12'h000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pc_sequencer #(.RESET_PC(12'hFFE)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    logic [W-1:0] exp_q[$];

    // Reference model: what the sequencer is doing, in plain terms.
    logic [W-1:0] m_pc;
    bit           m_boot;
    bit           m_flushing;
    bit           m_halt;
    bit           m_err;
    logic [W-1:0] m_ras[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_pc       = 12'h000;
            m_boot     = 1'b1;
            m_flushing = 1'b0;
            m_halt     = 1'b0;
            m_err      = 1'b0;
            m_ras.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_flushing) begin
            m_flushing = 1'b0;
        end else if (m_halt) begin
            if (bus.resume && !bus.halt_req) m_halt = 1'b0;
        end else if (bus.halt_req) begin
            m_halt = 1'b1;
        end else if (RAS_ON && bus.ret) begin
            if (m_ras.size() > 0) begin
                m_pc       = m_ras.pop_back();
                m_flushing = 1'b1;
            end else begin
                m_err = 1'b1;
                m_pc  = m_pc + 12'd1;
            end
        end else if (bus.call || bus.br_taken) begin
            if (RAS_ON && bus.call) begin
                m_ras.push_back(m_pc + 12'd1);
                if (m_ras.size() > RAS_DEPTH) begin
                    m_ras.delete(0);
                    m_err = 1'b1;
                end
            end
            m_pc       = bus.br_pc;
            m_flushing = 1'b1;
        end else if (!bus.stall) begin
            m_pc = m_pc + 12'd1;
        end
        exp_q.push_back(m_pc);
    endtask

    task automatic check_outputs();
        check_eq("pc", bus.pc, exp_q.pop_front());
        check_eq("pc_valid", bus.pc_valid, !(m_boot || m_flushing || m_halt));
        check_eq("flush", bus.flush, m_flushing);
        check_eq("halted", bus.halted, m_halt);
        check_eq("ras_err", bus.ras_err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic idle();
        bus.stall    = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_pc    = '0;
        bus.call     = 1'b0;
        bus.ret      = 1'b0;
        bus.halt_req = 1'b0;
        bus.resume   = 1'b0;
    endtask

    task automatic goto_pc(input logic [W-1:0] a);
        bus.br_taken = 1'b1;
        bus.br_pc    = a;
        tick();
        idle();
        tick();
    endtask

    initial begin
        logic [W-1:0] ret_exp [4];
        idle();
        bus_b.stall    = 1'b0;
        bus_b.br_taken = 1'b0;
        bus_b.br_pc    = '0;
        bus_b.call     = 1'b0;
        bus_b.ret      = 1'b0;
        bus_b.halt_req = 1'b0;
        bus_b.resume   = 1'b0;

        // Reset and boot, both reset vectors.
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_pc", bus.pc, 12'h000);
        check_eq("rst_valid", bus.pc_valid, 1'b0);
        check_eq("rst_b_pc", bus_b.pc, 12'hFFE);
        rst_n = 1'b1;
        tick();
        check_eq("boot_valid", bus.pc_valid, 1'b1);
        check_eq("boot_pc", bus.pc, 12'h000);
        check_eq("boot_b_pc", bus_b.pc, 12'hFFE);
        check_eq("boot_b_valid", bus_b.pc_valid, 1'b1);
        tick();
        check_eq("inc_pc", bus.pc, 12'h001);
        check_eq("inc_b_pc", bus_b.pc, 12'hFFF);
        tick();
        check_eq("wrap_b_pc", bus_b.pc, 12'h000);
        repeat (14) tick();
        check_eq("run_pc", bus.pc, 12'h010);

        // Branch at 010.
        bus.br_taken = 1'b1;
        bus.br_pc    = 12'h3A0;
        tick();
        idle();
        check_eq("br_pc", bus.pc, 12'h3A0);
        check_eq("br_flush", bus.flush, 1'b1);
        check_eq("br_valid0", bus.pc_valid, 1'b0);
        tick();
        check_eq("br_valid1", bus.pc_valid, 1'b1);
        check_eq("br_hold_pc", bus.pc, 12'h3A0);
        tick();
        check_eq("br_next_pc", bus.pc, 12'h3A1);

        // Redirect beats stall; then stall alone.
        goto_pc(12'h020);
        bus.stall    = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_pc    = 12'h100;
        tick();
        idle();
        check_eq("stbr_pc", bus.pc, 12'h100);
        check_eq("stbr_flush", bus.flush, 1'b1);
        tick();
        goto_pc(12'h020);
        bus.stall = 1'b1;
        repeat (3) begin
            tick();
            check_eq("stall_pc", bus.pc, 12'h020);
            check_eq("stall_valid", bus.pc_valid, 1'b1);
        end
        idle();
        tick();
        check_eq("unstall_pc", bus.pc, 12'h021);

`ifdef RAS_EN
        // Call/return, then overflow and underflow of the stack.
        goto_pc(12'h050);
        bus.call  = 1'b1;
        bus.br_pc = 12'h200;
        tick();
        idle();
        check_eq("call_pc", bus.pc, 12'h200);
        repeat (3) tick();
        bus.ret = 1'b1;
        tick();
        idle();
        check_eq("ret_pc", bus.pc, 12'h051);
        check_eq("ret_flush", bus.flush, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.call  = 1'b1;
            bus.br_pc = 12'h300 + 12'(16 * i);
            tick();
            idle();
            tick();
        end
        check_eq("ovf_err", bus.ras_err, 1'b1);
        ret_exp[0] = 12'h331;
        ret_exp[1] = 12'h321;
        ret_exp[2] = 12'h311;
        ret_exp[3] = 12'h301;
        for (int i = 0; i < 4; i++) begin
            bus.ret = 1'b1;
            tick();
            idle();
            check_eq("pop_pc", bus.pc, ret_exp[i]);
            check_eq("pop_flush", bus.flush, 1'b1);
            tick();
        end
        bus.ret = 1'b1;
        tick();
        idle();
        check_eq("unf_pc", bus.pc, 12'h302);
        check_eq("unf_flush", bus.flush, 1'b0);
        check_eq("unf_err", bus.ras_err, 1'b1);
`else
        ret_exp[0] = 12'h0;
        bus.ret = 1'b1;
        tick();
        idle();
        check_eq("ret_ignored_flush", bus.flush, 1'b0);
        check_eq("ret_ignored_pc", bus.pc, 12'h022 + ret_exp[0]);
`endif

        // Halt beats branch; resume; halt+resume together; reset in halt.
        goto_pc(12'h070);
        bus.halt_req = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_pc    = 12'h555;
        tick();
        idle();
        check_eq("halt_halted", bus.halted, 1'b1);
        check_eq("halt_pc", bus.pc, 12'h070);
        check_eq("halt_valid", bus.pc_valid, 1'b0);
        repeat (4) tick();
        check_eq("halt_frozen_pc", bus.pc, 12'h070);
        bus.resume = 1'b1;
        tick();
        idle();
        check_eq("resume_halted", bus.halted, 1'b0);
        check_eq("resume_valid", bus.pc_valid, 1'b1);
        check_eq("resume_pc", bus.pc, 12'h070);
        tick();
        check_eq("resume_next_pc", bus.pc, 12'h071);
        bus.halt_req = 1'b1;
        tick();
        bus.resume = 1'b1;
        tick();
        idle();
        check_eq("halt_both", bus.halted, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("halt_rst_pc", bus.pc, 12'h000);
        check_eq("halt_rst_halted", bus.halted, 1'b0);
        tick();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            bus.halt_req = ($urandom_range(0, 24) == 0);
            bus.resume   = ($urandom_range(0, 3) == 0);
            bus.stall    = ($urandom_range(0, 4) == 0);
            bus.br_taken = ($urandom_range(0, 6) == 0);
            bus.call     = ($urandom_range(0, 7) == 0);
            bus.ret      = ($urandom_range(0, 7) == 0);
            bus.br_pc    = W'($urandom_range(0, 4095));
            tick();
        end
        rst_n = 1'b1;
        idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequential controller that owns the 12-bit program counter and drives the next-PC selection previously made by a bare select mux. It arbitrates redirect requests (branch, call, return), stalls and halt/resume, and issues a one-cycle flush after every redirect. It sits between the execute/branch unit and instruction memory, and is the single source of fetch addresses for the RISC core.

## Interface
- PC_W, 12, program-counter width; wraps mod 2^PC_W
- RESET_PC, 12'h000, PC loaded on reset
- RAS_DEPTH, 4, return-address-stack entries (only with RAS_EN)

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC this cycle
- br_taken  in  1  taken branch/jump; target on br_pc
- br_pc  in  PC_W  branch/call target
- call  in  1  call to br_pc; push return address
- ret  in  1  return to popped address
- halt_req  in  1  enter HALT
- resume  in  1  leave HALT
- pc  out  PC_W  current fetch address
- pc_valid  out  1  pc is a real fetch this cycle
- flush  out  1  discard in-flight instructions
- halted  out  1  block is in HALT
- ras_err  out  1  sticky RAS overflow/underflow

## Operation
- States: BOOT, RUN, FLUSH, HALT. All outputs registered.
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=BOOT, pc_valid=0, flush=0, halted=0, ras_err=0, RAS empty. Reset mid-operation behaves identically and discards any pending request.
- BOOT: one cycle, then RUN. Inputs ignored.
- RUN: fixed priority per cycle: halt_req > ret > call > br_taken > stall > increment.
  - increment: pc <= pc+1; 12'hFFF wraps to 12'h000.
  - stall: pc holds; pc_valid stays 1.
  - br_taken: pc <= br_pc, then FLUSH.
  - call: push pc+1 (wrapped), pc <= br_pc, then FLUSH.
  - ret: pop, pc <= popped value, then FLUSH.
  - halt_req: pc holds, then HALT. A simultaneous redirect is dropped.
  - A redirect in the same cycle as stall wins; the stall is ignored.
- FLUSH: one cycle with flush=1 and pc_valid=0, pc = target. Then RUN. All requests are ignored; requesters must re-assert.
- HALT: halted=1, pc_valid=0, pc frozen. resume returns to RUN, with pc_valid=1 in the next cycle. halt_req and resume together keep the block in HALT.
- RAS is circular, RAS_DEPTH entries.
  - Push when full: overwrites the oldest entry and sets ras_err.
  - Pop when empty: treated as increment (no FLUSH) and sets ras_err.
  - ras_err is cleared only by reset.

## Timing
- A request sampled at edge N gives pc=target and flush=1 from N+1, and pc_valid=1 from N+2.
- Increment: pc advances every cycle in RUN with no stall or request.
- BOOT: first pc_valid=1 occurs two cycles after rst_n deasserts (BOOT cycle, then RUN).
- halt_req at N gives halted=1 and pc_valid=0 from N+1. resume at M gives halted=0 and pc_valid=1 from M+1.
- Zero combinational paths from inputs to outputs.

## Configuration
- RAS_EN defined: the return-address stack is instantiated, and call/ret behave as above.
- RAS_EN undefined:
  - No stack.
  - call behaves exactly as br_taken (no push).
  - ret is ignored: increment, or stall if stall is asserted.
  - ras_err is tied to 0.
  - RAS_DEPTH is unused.

## Structure
- Shared package pc_seq_pkg holds PC_W, RESET_PC, the state encoding (BOOT, RUN, FLUSH, HALT) and the redirect-cause encoding.
- One sub-module: ret_addr_stack.
  - Inputs: push, pop, wdata.
  - Outputs: rdata, empty, full, err.
  - Compiled only under RAS_EN.
- The existing next-PC select is absorbed into the RUN-state next-pc logic.

## Test plan
- Reset, then free-run: pc 000, 000 (BOOT), 001, 002, ... and pc_valid=0 until the second cycle after rst_n=1. Start from RESET_PC=12'hFFE: sequence FFE, FFF, 000.
- br_taken with br_pc=12'h3A0 at pc=12'h010: next cycle pc=3A0, flush=1, pc_valid=0. The cycle after, pc=3A0, pc_valid=1. Then 3A1.
- stall and br_taken together at pc=12'h020 with br_pc=12'h100: redirect taken, giving pc=100 and flush. stall alone holds pc=020 for 3 cycles with pc_valid=1.
- RAS_EN: call to 12'h200 at pc=12'h050, run, then ret, giving pc=12'h051 with flush. Five calls with no ret give ras_err=1. Then 5 rets: 4 return addresses pop in reverse order, and the fifth ret increments with no flush.
- halt_req with br_taken together at pc=12'h070: halted=1, pc stays 070, branch dropped. resume after 4 cycles gives pc_valid=1, pc=070, then 071. Assert rst_n=0 during HALT: pc=RESET_PC, halted=0.
